// File: rtl/tt_pkg.sv
// Shared types, constants and helpers for the truth-table sweeper.
package tt_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      DONE
   } tt_state_t;

   localparam int TT_MAX_N_IN = 8;
   localparam int TT_CNT_W    = 8;

   function automatic int tt_table_w(input int n);
      return 1 << n;
   endfunction

endpackage

// File: rtl/tt_gray_enc.sv
// Binary-to-Gray encoder used to order the input sweep so that only one
// input bit changes between consecutive vectors.
module tt_gray_enc #(
   parameter int W = 3
) (
   input  logic [W-1:0] bin,
   output logic [W-1:0] gray
);

   // Each Gray bit is the XOR of the matching binary bit and the one above it.
   always_comb begin
      gray = bin ^ (bin >> 1);
   end

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives every input combination onto a small
// combinational unit, waits SETTLE extra cycles per vector, samples the
// unit's output into table_out and compares the table against expected.
// Optional build macro TT_GRAY_SWEEP_EN walks the vectors in Gray order
// instead of binary order; the captured table is identical either way.
module truth_table_sweeper
   import tt_pkg::*;
#(
   parameter int N_IN   = 2,
   parameter int SETTLE = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [tt_table_w(N_IN)-1:0]   expected,
   input  logic                          dut_out,
   output logic [N_IN-1:0]               dut_in,
   output logic                          busy,
   output logic                          done,
   output logic [tt_table_w(N_IN)-1:0]   table_out,
   output logic                          match
);

   localparam int                  K_W        = N_IN + 1;
   localparam logic [TT_CNT_W-1:0] SETTLE_CNT = TT_CNT_W'(SETTLE);

   tt_state_t           state;
   logic [K_W-1:0]      k;
   logic [TT_CNT_W-1:0] cnt;
   logic [K_W-1:0]      k_next;
   logic [K_W-1:0]      vec_next;

   // Step index of the vector that follows the one currently driven.
   always_comb begin
      k_next = k + K_W'(1);
   end

   // Map the next step index onto the input vector actually driven. The top
   // bit of vec_next equals the top bit of k_next in both orders, so it also
   // flags that the last vector has just been sampled.
`ifdef TT_GRAY_SWEEP_EN
   tt_gray_enc #(
      .W (K_W)
   ) u_gray_enc (
      .bin  (k_next),
      .gray (vec_next)
   );
`else
   always_comb begin
      vec_next = k_next;
   end
`endif

   // Sweep sequencer: accept start, hold each vector for SETTLE+1 cycles,
   // capture the sampled output by vector value, then report and compare.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= tt_pkg::IDLE;
         k         <= '0;
         cnt       <= '0;
         dut_in    <= '0;
         table_out <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         match     <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            tt_pkg::IDLE: begin
               if (start) begin
                  k         <= '0;
                  dut_in    <= '0;
                  cnt       <= SETTLE_CNT;
                  table_out <= '0;
                  match     <= 1'b0;
                  busy      <= 1'b1;
                  state     <= tt_pkg::SETTLE;
               end
            end
            tt_pkg::SETTLE: begin
               if (cnt != '0) begin
                  cnt <= cnt - TT_CNT_W'(1);
               end else begin
                  table_out[dut_in] <= dut_out;
                  if (vec_next[N_IN]) begin
                     state <= tt_pkg::DONE;
                  end else begin
                     k      <= k_next;
                     dut_in <= vec_next[N_IN-1:0];
                     cnt    <= SETTLE_CNT;
                  end
               end
            end
            tt_pkg::DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               match <= (table_out == expected);
               state <= tt_pkg::IDLE;
            end
            default: begin
               state <= tt_pkg::IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Testbench for truth_table_sweeper. Two instances are used: one with
// SETTLE=1 and one with SETTLE=0, both N_IN=2. The unit under test is a
// small selectable combinational model inside the bench. When built with
// TT_GRAY_SWEEP_EN the expected dut_in order switches to Gray order.
module tb_truth_table_sweeper;

   localparam int MODEL_EXPR = 0;
   localparam int MODEL_XOR  = 1;
   localparam int MODEL_AND  = 2;

   typedef struct {
      int         inst;
      int         m;
      logic [3:0] exp_vec;
      logic [3:0] exp_table;
      logic       exp_match;
      int         settle;
      int         exp_done;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_a, start_b;
   logic [3:0] expected_a, expected_b;
   logic       dut_out_a, dut_out_b;
   logic [1:0] dut_in_a, dut_in_b;
   logic       busy_a, busy_b, done_a, done_b, match_a, match_b;
   logic [3:0] table_a, table_b;
   int         model;

   int         n_compared   = 0;
   int         n_mismatched = 0;

   logic [1:0] seq_exp [4];
   logic [1:0] din_log [64];
   logic       busy_log [64];
   int         done_at;
   logic [3:0] table_at_done;
   logic       match_at_done;
   logic       busy_at_done;
   vec_t       vecs [5];

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Small combinational units the sweeper characterises; a = dut_in[1], b = dut_in[0].
   function automatic logic unit_model(input int m, input logic [1:0] v);
      logic a, b;
      a = v[1];
      b = v[0];
      case (m)
         MODEL_EXPR: return ~((a ^ b) & ~(~a | ~b));
         MODEL_XOR:  return a ^ b;
         default:    return a & b;
      endcase
   endfunction

   assign dut_out_a = unit_model(model, dut_in_a);
   assign dut_out_b = unit_model(model, dut_in_b);

   truth_table_sweeper #(
      .N_IN   (2),
      .SETTLE (1)
   ) dut_a (
      .clk       (clk),
      .rst       (rst),
      .start     (start_a),
      .expected  (expected_a),
      .dut_out   (dut_out_a),
      .dut_in    (dut_in_a),
      .busy      (busy_a),
      .done      (done_a),
      .table_out (table_a),
      .match     (match_a)
   );

   truth_table_sweeper #(
      .N_IN   (2),
      .SETTLE (0)
   ) dut_b (
      .clk       (clk),
      .rst       (rst),
      .start     (start_b),
      .expected  (expected_b),
      .dut_out   (dut_out_b),
      .dut_in    (dut_in_b),
      .busy      (busy_b),
      .done      (done_b),
      .table_out (table_b),
      .match     (match_b)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] want);
      n_compared++;
      if (actual !== want) begin
         n_mismatched++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, want);
      end
   endtask

   // Launch one sweep on instance inst and log dut_in/busy every cycle (sampled
   // at negedge, e = edges after the start edge) until done or the bound runs out.
   task automatic applyStimulus(input int inst, input int m, input logic [3:0] exp_vec, input bit hold_start);
      logic [1:0] din;
      logic       bsy;
      logic       dn;
      model = m;
      @(negedge clk);
      if (inst == 0) begin
         expected_a = exp_vec;
         start_a    = 1'b1;
      end else begin
         expected_b = exp_vec;
         start_b    = 1'b1;
      end
      for (int e = 0; e < 64; e++) begin
         din_log[e]  = 'x;
         busy_log[e] = 'x;
      end
      done_at       = -1;
      table_at_done = 'x;
      match_at_done = 'x;
      busy_at_done  = 'x;
      @(posedge clk);
      for (int e = 0; e < 40 && done_at < 0; e++) begin
         @(negedge clk);
         if (!hold_start) begin
            start_a = 1'b0;
            start_b = 1'b0;
         end
         din = (inst == 0) ? dut_in_a : dut_in_b;
         bsy = (inst == 0) ? busy_a   : busy_b;
         dn  = (inst == 0) ? done_a   : done_b;
         din_log[e]  = din;
         busy_log[e] = bsy;
         if (dn === 1'b1) begin
            done_at       = e;
            table_at_done = (inst == 0) ? table_a : table_b;
            match_at_done = (inst == 0) ? match_a : match_b;
            busy_at_done  = bsy;
         end
      end
   endtask

   task automatic checkSweep(input string tag, input int settle, input logic [3:0] exp_table,
                             input logic exp_match, input int exp_done);
      checkOutput({tag, "_done_at"}, done_at, exp_done);
      checkOutput({tag, "_table"}, {28'd0, table_at_done}, {28'd0, exp_table});
      checkOutput({tag, "_match"}, {31'd0, match_at_done}, {31'd0, exp_match});
      checkOutput({tag, "_busy_in_done"}, {31'd0, busy_at_done}, 32'd0);
      checkOutput({tag, "_busy_first"}, {31'd0, busy_log[0]}, 32'd1);
      for (int j = 0; j < 4; j++) begin
         checkOutput($sformatf("%s_vec%0d_first", tag, j), {30'd0, din_log[j*(settle+1)]}, {30'd0, seq_exp[j]});
         checkOutput($sformatf("%s_vec%0d_last", tag, j), {30'd0, din_log[j*(settle+1)+settle]}, {30'd0, seq_exp[j]});
      end
   endtask

   // Abort the run if anything above hangs.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main test sequence.
   initial begin
      int done_count;
      int second_done;
      logic [3:0] second_table;
      logic second_match;

`ifdef TT_GRAY_SWEEP_EN
      seq_exp = '{2'd0, 2'd1, 2'd3, 2'd2};
`else
      seq_exp = '{2'd0, 2'd1, 2'd2, 2'd3};
`endif

      vecs[0] = '{0, MODEL_EXPR, 4'b1111, 4'b1111, 1'b1, 1, 9};
      vecs[1] = '{0, MODEL_XOR,  4'b1111, 4'b0110, 1'b0, 1, 9};
      vecs[2] = '{1, MODEL_AND,  4'b1000, 4'b1000, 1'b1, 0, 5};
      vecs[3] = '{1, MODEL_XOR,  4'b0110, 4'b0110, 1'b1, 0, 5};
      vecs[4] = '{0, MODEL_AND,  4'b0000, 4'b1000, 1'b0, 1, 9};

      rst        = 1'b1;
      start_a    = 1'b0;
      start_b    = 1'b0;
      expected_a = 4'b0000;
      expected_b = 4'b0000;
      model      = MODEL_EXPR;

      repeat (2) @(negedge clk);
      checkOutput("reset_dut_in_a", {30'd0, dut_in_a}, 32'd0);
      checkOutput("reset_busy_a",   {31'd0, busy_a},   32'd0);
      checkOutput("reset_done_a",   {31'd0, done_a},   32'd0);
      checkOutput("reset_table_a",  {28'd0, table_a},  32'd0);
      checkOutput("reset_match_a",  {31'd0, match_a},  32'd0);
      checkOutput("reset_busy_b",   {31'd0, busy_b},   32'd0);
      checkOutput("reset_table_b",  {28'd0, table_b},  32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i].inst, vecs[i].m, vecs[i].exp_vec, 1'b0);
         checkSweep($sformatf("vec%0d", i), vecs[i].settle, vecs[i].exp_table, vecs[i].exp_match, vecs[i].exp_done);
         repeat (2) @(negedge clk);
         if (vecs[i].inst == 0) begin
            checkOutput($sformatf("vec%0d_hold_dut_in", i), {30'd0, dut_in_a}, {30'd0, seq_exp[3]});
            checkOutput($sformatf("vec%0d_hold_table", i), {28'd0, table_a}, {28'd0, vecs[i].exp_table});
            checkOutput($sformatf("vec%0d_hold_match", i), {31'd0, match_a}, {31'd0, vecs[i].exp_match});
         end else begin
            checkOutput($sformatf("vec%0d_hold_dut_in", i), {30'd0, dut_in_b}, {30'd0, seq_exp[3]});
            checkOutput($sformatf("vec%0d_hold_table", i), {28'd0, table_b}, {28'd0, vecs[i].exp_table});
            checkOutput($sformatf("vec%0d_hold_match", i), {31'd0, match_b}, {31'd0, vecs[i].exp_match});
         end
      end

      // start held high: one sweep, then a second accepted right after done.
      applyStimulus(0, MODEL_XOR, 4'b0110, 1'b1);
      checkOutput("hold_first_done_at", done_at, 9);
      checkOutput("hold_first_table", {28'd0, table_at_done}, 32'h6);
      @(negedge clk);
      checkOutput("hold_restart_busy",  {31'd0, busy_a},  32'd1);
      checkOutput("hold_restart_table", {28'd0, table_a}, 32'd0);
      checkOutput("hold_restart_match", {31'd0, match_a}, 32'd0);
      checkOutput("hold_restart_done",  {31'd0, done_a},  32'd0);
      second_done  = -1;
      second_table = 'x;
      second_match = 'x;
      for (int e = 11; e < 60 && second_done < 0; e++) begin
         @(negedge clk);
         if (done_a === 1'b1) begin
            second_done  = e;
            second_table = table_a;
            second_match = match_a;
         end
      end
      start_a = 1'b0;
      checkOutput("hold_second_done_at", second_done, 19);
      checkOutput("hold_second_table", {28'd0, second_table}, 32'h6);
      checkOutput("hold_second_match", {31'd0, second_match}, 32'd1);
      repeat (3) @(negedge clk);

      // Reset during the third vector aborts the sweep without a done pulse.
      model = MODEL_XOR;
      @(negedge clk);
      expected_a = 4'b0110;
      start_a    = 1'b1;
      @(posedge clk);
      for (int e = 0; e < 5; e++) begin
         @(negedge clk);
         start_a = 1'b0;
      end
      checkOutput("rst_pre_dut_in", {30'd0, dut_in_a}, {30'd0, seq_exp[2]});
      rst = 1'b1;
      @(negedge clk);
      checkOutput("rst_dut_in", {30'd0, dut_in_a}, 32'd0);
      checkOutput("rst_busy",   {31'd0, busy_a},   32'd0);
      checkOutput("rst_done",   {31'd0, done_a},   32'd0);
      checkOutput("rst_table",  {28'd0, table_a},  32'd0);
      checkOutput("rst_match",  {31'd0, match_a},  32'd0);
      rst = 1'b0;
      done_count = 0;
      for (int e = 0; e < 15; e++) begin
         @(negedge clk);
         if (done_a === 1'b1) done_count++;
      end
      checkOutput("rst_no_done", done_count, 0);
      checkOutput("rst_stays_idle", {31'd0, busy_a}, 32'd0);

      applyStimulus(0, MODEL_XOR, 4'b0110, 1'b0);
      checkSweep("post_rst", 1, 4'b0110, 1'b1, 9);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
